// File: rtl/morra_match_sequencer.sv
// Best-of-N tournament sequencer around a MorraCinese core. It configures each
// match, forwards one move pair per round and tallies match wins.
module morra_match_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic [2:0] cfg_matches,
    input  logic [3:0] cfg_len,
    input  logic       mv_valid,
    input  logic [1:0] mv_p1,
    input  logic [1:0] mv_p2,
    output logic       mv_ready,
    output logic [1:0] core_p1,
    output logic [1:0] core_p2,
    output logic       core_start,
    input  logic [1:0] core_round,
    input  logic [1:0] core_game,
    output logic       busy,
    output logic [2:0] match_idx,
    output logic [2:0] wins_p1,
    output logic [2:0] wins_p2,
    output logic       done,
    output logic [1:0] winner,
    output logic       err
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONFIG  = 3'd1,
        WAIT_MV = 3'd2,
        ISSUE   = 3'd3,
        CHECK   = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t     state_r, state_s;
    logic [2:0] matches_r, match_idx_r, wins_p1_r, wins_p2_r;
    logic [3:0] len_r, len_s;
    logic [4:0] round_cnt_r, round_inc_s;
    logic [1:0] winner_r, core_p1_r, core_p2_r, core_p1_s, core_p2_s;
    logic       err_r, busy_r, mv_ready_r, core_start_r, done_r;
    logic       busy_s, mv_ready_s, core_start_s, done_s;
    logic       timeout_s, match_end_s, last_match_s, handshake_s;
    logic [2:0] wins_p1_s, wins_p2_s, target_s, idx_inc_s;
    logic       unused_round_s;

    // The round code is informational only; match outcome comes from core_game.
    assign unused_round_s = ^core_round;

    function automatic logic [1:0] decide_winner(input logic [2:0] w1, input logic [2:0] w2);
        if (w1 > w2) begin
            decide_winner = 2'b01;
        end else if (w2 > w1) begin
            decide_winner = 2'b10;
        end else begin
            decide_winner = 2'b11;
        end
    endfunction

    assign handshake_s = mv_valid && mv_ready_r;

    // Evaluate the core result seen in CHECK: match end, updated tallies, tournament end.
    always_comb begin
        round_inc_s = round_cnt_r + 5'd1;
        target_s    = {1'b0, matches_r[2:1]} + 3'd1;
        idx_inc_s   = match_idx_r + 3'd1;
        timeout_s   = (core_game == 2'b00) && (round_inc_s >= 5'd20);
        match_end_s = (core_game != 2'b00) || timeout_s;
        wins_p1_s   = wins_p1_r;
        wins_p2_s   = wins_p2_r;
        if (core_game == 2'b01) begin
            wins_p1_s = wins_p1_r + 3'd1;
        end else if (core_game == 2'b10) begin
            wins_p2_s = wins_p2_r + 3'd1;
        end else begin
            wins_p1_s = wins_p1_r;
        end
        last_match_s = (wins_p1_s >= target_s) || (wins_p2_s >= target_s) ||
                       (idx_inc_s == matches_r);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = cfg_start ? CONFIG : IDLE;
            CONFIG:  state_s = WAIT_MV;
            WAIT_MV: state_s = handshake_s ? ISSUE : WAIT_MV;
            ISSUE:   state_s = CHECK;
            CHECK: begin
                if (match_end_s) begin
                    state_s = last_match_s ? FINISH : CONFIG;
                end else begin
                    state_s = WAIT_MV;
                end
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        busy_s       = (state_s != IDLE);
        mv_ready_s   = (state_s == WAIT_MV);
        core_start_s = (state_s == CONFIG);
        done_s       = (state_s == FINISH);
        len_s        = (state_r == IDLE) ? cfg_len : len_r;
        core_p1_s    = 2'b00;
        core_p2_s    = 2'b00;
        case (state_s)
            CONFIG: begin
                core_p1_s = len_s[3:2];
                core_p2_s = len_s[1:0];
            end
            ISSUE: begin
                core_p1_s = mv_p1;
                core_p2_s = mv_p2;
            end
            default: begin
                core_p1_s = 2'b00;
                core_p2_s = 2'b00;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            mv_ready_r   <= 1'b0;
            core_start_r <= 1'b0;
            done_r       <= 1'b0;
            core_p1_r    <= 2'b00;
            core_p2_r    <= 2'b00;
        end else begin
            busy_r       <= busy_s;
            mv_ready_r   <= mv_ready_s;
            core_start_r <= core_start_s;
            done_r       <= done_s;
            core_p1_r    <= core_p1_s;
            core_p2_r    <= core_p2_s;
        end
    end

    // Tournament configuration, round counter and score tallies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matches_r   <= 3'd1;
            len_r       <= 4'd0;
            round_cnt_r <= 5'd0;
            match_idx_r <= 3'd0;
            wins_p1_r   <= 3'd0;
            wins_p2_r   <= 3'd0;
            winner_r    <= 2'b00;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg_start) begin
                        matches_r   <= (cfg_matches == 3'd0) ? 3'd1 : cfg_matches;
                        len_r       <= cfg_len;
                        round_cnt_r <= 5'd0;
                        match_idx_r <= 3'd0;
                        wins_p1_r   <= 3'd0;
                        wins_p2_r   <= 3'd0;
                        winner_r    <= 2'b00;
                        err_r       <= 1'b0;
                    end
                end
                CONFIG: round_cnt_r <= 5'd0;
                CHECK: begin
                    round_cnt_r <= round_inc_s;
                    wins_p1_r   <= wins_p1_s;
                    wins_p2_r   <= wins_p2_s;
                    if (timeout_s) begin
                        err_r <= 1'b1;
                    end
                    if (match_end_s) begin
                        if (last_match_s) begin
                            winner_r <= decide_winner(wins_p1_s, wins_p2_s);
                        end else begin
                            match_idx_r <= idx_inc_s;
                        end
                    end
                end
                default: round_cnt_r <= round_cnt_r;
            endcase
        end
    end

    assign busy       = busy_r;
    assign mv_ready   = mv_ready_r;
    assign core_start = core_start_r;
    assign done       = done_r;
    assign core_p1    = core_p1_r;
    assign core_p2    = core_p2_r;
    assign match_idx  = match_idx_r;
    assign wins_p1    = wins_p1_r;
    assign wins_p2    = wins_p2_r;
    assign winner     = winner_r;
    assign err        = err_r;
endmodule

// File: tb/tb_morra_match_sequencer.sv
// Scoreboard bench for morra_match_sequencer with a scripted MorraCinese core stub.
module tb_morra_match_sequencer;
    logic       clk, rst_n, cfg_start, mv_valid, mv_ready, core_start, busy, done, err;
    logic [2:0] cfg_matches, match_idx, wins_p1, wins_p2;
    logic [3:0] cfg_len;
    logic [1:0] mv_p1, mv_p2, core_p1, core_p2, core_round, core_game, winner;

    morra_match_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_matches(cfg_matches),
        .cfg_len(cfg_len), .mv_valid(mv_valid), .mv_p1(mv_p1), .mv_p2(mv_p2),
        .mv_ready(mv_ready), .core_p1(core_p1), .core_p2(core_p2), .core_start(core_start),
        .core_round(core_round), .core_game(core_game), .busy(busy), .match_idx(match_idx),
        .wins_p1(wins_p1), .wins_p2(wins_p2), .done(done), .winner(winner), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub script: match m ends on its end_move[m]-th move with result end_game[m].
    int         end_move [0:7];
    logic [1:0] end_game [0:7];
    int         stub_match, stub_mcnt;

    // Core stub: one-clock latency from the ISSUE-cycle moves to core_game.
    always @(posedge clk) begin
        if (!rst_n || (cfg_start && !busy)) begin
            stub_match <= -1;
            stub_mcnt  <= 0;
            core_game  <= 2'b00;
            core_round <= 2'b00;
        end else if (core_start) begin
            stub_match <= stub_match + 1;
            stub_mcnt  <= 0;
            core_game  <= 2'b00;
        end else if (core_p1 != 2'b00 || core_p2 != 2'b00) begin
            stub_mcnt  <= stub_mcnt + 1;
            core_round <= (core_p1 == core_p2) ? 2'b11 : 2'b01;
            if (stub_match >= 0 && stub_mcnt + 1 == end_move[stub_match[2:0]])
                core_game <= end_game[stub_match[2:0]];
            else
                core_game <= 2'b00;
        end else begin
            core_game <= 2'b00;
        end
    end

    int          checks, errors, hs_cnt, done_cnt;
    logic [3:0]  exp_mv_q [$];
    logic [11:0] exp_res_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_script(input int m0, m1, m2, input logic [1:0] g0, g1, g2);
        for (int i = 0; i < 8; i++) begin
            end_move[i] = 1;
            end_game[i] = 2'b01;
        end
        end_move[0] = m0; end_move[1] = m1; end_move[2] = m2;
        end_game[0] = g0; end_game[1] = g1; end_game[2] = g2;
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 800 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done pulse required one within 800 cycles", name);
        end
    endtask

    task automatic start_tm(input logic [2:0] m, input logic [3:0] len);
        @(negedge clk);
        cfg_matches = m;
        cfg_len     = len;
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic finish_tm(input string name, input int hs0, input int exp_hs, input logic [11:0] exp_res);
        wait_done(name);
        repeat (3) @(negedge clk);
        check({name, "_hold"}, {busy, winner, wins_p1, wins_p2, match_idx, err}, {1'b0, exp_res});
        check({name, "_moves"}, hs_cnt - hs0, exp_hs);
    endtask

    task automatic run_tm(input string name, input logic [2:0] m, input logic [3:0] len,
                          input int exp_hs, input logic [11:0] exp_res);
        int hs0;
        hs0 = hs_cnt;
        exp_res_q.push_back(exp_res);
        start_tm(m, len);
        finish_tm(name, hs0, exp_hs, exp_res);
    endtask

    initial begin
        int hs0;
        logic found;
        checks = 0; errors = 0; hs_cnt = 0; done_cnt = 0;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_matches = 3'd0; cfg_len = 4'd0;
        mv_valid = 1'b0; mv_p1 = 2'b00; mv_p2 = 2'b00;
        set_script(1, 1, 1, 2'b01, 2'b01, 2'b01);

        fork
            // Move driver: a new pair after each accepted one; p2 includes 00.
            forever begin
                @(negedge clk);
                mv_p1 = 2'(hs_cnt % 3 + 1);
                mv_p2 = 2'(hs_cnt % 4);
            end
            // Handshake capture: record every accepted pair for the ISSUE monitor.
            forever begin
                @(posedge clk);
                if (rst_n && mv_valid && mv_ready) begin
                    exp_mv_q.push_back({mv_p1, mv_p2});
                    hs_cnt++;
                end
            end
            // ISSUE monitor: forwarded moves must match accepted pairs in order.
            forever begin
                @(negedge clk);
                if (rst_n && !core_start && (core_p1 != 2'b00 || core_p2 != 2'b00)) begin
                    if (exp_mv_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL issue_move: got 0x%0h with no accepted move pending", {core_p1, core_p2});
                    end else begin
                        check("issue_move", {core_p1, core_p2}, exp_mv_q.pop_front());
                    end
                end
            end
            // Done monitor: compare the tournament result against the scoreboard.
            forever begin
                @(negedge clk);
                if (done) begin
                    if (exp_res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 required no pulse");
                    end else begin
                        check("result", {winner, wins_p1, wins_p2, match_idx, err}, exp_res_q.pop_front());
                    end
                    done_cnt++;
                end
            end
            begin
                #200000;
                $display("FAIL global_timeout: simulation exceeded time limit");
                $fatal(1, "global timeout");
            end
        join_none

        repeat (2) @(negedge clk);
        check("reset_state",
              {busy, mv_ready, core_start, done, err, core_p1, core_p2, winner, wins_p1, wins_p2, match_idx},
              20'd0);
        rst_n = 1'b1;
        mv_valid = 1'b1;

        // Best of 3, P1 takes matches 0 and 1; stray cfg_start while busy.
        set_script(4, 4, 4, 2'b01, 2'b01, 2'b01);
        hs0 = hs_cnt;
        exp_res_q.push_back({2'b01, 3'd2, 3'd0, 3'd1, 1'b0});
        start_tm(3'd3, 4'b0110);
        check("config_cycle", {core_start, core_p1, core_p2, busy, mv_ready}, {1'b1, 2'b01, 2'b10, 1'b1, 1'b0});
        @(negedge clk);
        check("wait_mv_cycle", {mv_ready, busy, core_start}, 3'b110);
        cfg_matches = 3'd0; cfg_len = 4'b1111; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("busy_start_ignored", {core_start, match_idx}, 4'd0);
        finish_tm("p1_best_of_3", hs0, 8, {2'b01, 3'd2, 3'd0, 3'd1, 1'b0});

        // Two matches split one each: tie.
        set_script(3, 5, 1, 2'b01, 2'b10, 2'b01);
        run_tm("split_tie", 3'd2, 4'b1001, 8, {2'b11, 3'd1, 3'd1, 3'd1, 1'b0});

        // Match 0 never decided: watchdog after 20 moves, then P2 wins twice.
        set_script(0, 2, 2, 2'b00, 2'b10, 2'b10);
        run_tm("watchdog", 3'd3, 4'b0101, 24, {2'b10, 3'd0, 3'd2, 3'd2, 1'b1});

        // cfg_matches=0 behaves as a single match; err cleared on new start.
        set_script(1, 1, 1, 2'b10, 2'b01, 2'b01);
        run_tm("zero_matches", 3'd0, 4'b1110, 1, {2'b10, 3'd0, 3'd1, 3'd0, 1'b0});

        // Drawn matches still count as played.
        set_script(1, 2, 3, 2'b11, 2'b01, 2'b11);
        run_tm("draws", 3'd3, 4'b0011, 6, {2'b01, 3'd1, 3'd0, 3'd2, 1'b0});

        // Reset asserted during ISSUE abandons the tournament.
        set_script(2, 2, 2, 2'b01, 2'b01, 2'b01);
        start_tm(3'd3, 4'b0110);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (!core_start && core_p1 != 2'b00) found = 1'b1;
            else @(negedge clk);
        end
        check("issue_reached", {31'd0, found}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_mid_issue",
              {busy, mv_ready, core_start, done, err, core_p1, core_p2, winner, wins_p1, wins_p2, match_idx},
              20'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_script(2, 1, 1, 2'b01, 2'b01, 2'b01);
        run_tm("after_reset", 3'd1, 4'b0110, 2, {2'b01, 3'd1, 3'd0, 3'd0, 1'b0});

        repeat (5) @(negedge clk);
        check("result_queue_empty", exp_res_q.size(), 0);
        check("move_queue_empty", exp_mv_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
